// File: rtl/regfile_wb_scheduler.sv
// Round-robin writeback scheduler for the single register file write port,
// with a pending-write scoreboard for decode hazard stalls.
module regfile_wb_scheduler #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rsv_ready,
    input  logic [AW-1:0]        rs1_addr,
    input  logic [AW-1:0]        rs2_addr,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [2**AW-1:0]     busy_vec
);

    localparam int NREG = 2**AW;
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [AW-1:0]   gnt_addr;
    logic [XLEN-1:0] gnt_data;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic            commit_hit;
    int              scan;

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        scan      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            scan = (int'(rr_ptr) + k) % NREQ;
            if (!gnt_any && req_valid[scan]) begin
                gnt_any         = 1'b1;
                gnt_idx         = IW'(scan);
                req_ready[scan] = 1'b1;
            end
        end
    end

    assign gnt_addr = req_addr[int'(gnt_idx)*AW +: AW];
    assign gnt_data = req_data[int'(gnt_idx)*XLEN +: XLEN];

    // Writes to x0 are consumed here and never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= IW'(NREQ-1);
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (gnt_any) begin
            rr_ptr   <= gnt_idx;
            rf_we    <= (gnt_addr != '0);
            rf_waddr <= gnt_addr;
            rf_wdata <= gnt_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    assign commit_hit = rf_we && (rf_waddr == rsv_addr);
    assign rsv_ready  = !busy[rsv_addr] || commit_hit;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (rsv_valid && rsv_ready && (rsv_addr != '0))
            set_mask[rsv_addr] = 1'b1;
        if (rf_we)
            clr_mask[rf_waddr] = 1'b1;
    end

    // A new reservation on the committing register outlives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= ((busy & ~clr_mask) | set_mask) & ~NREG'(1);
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];
    assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_regfile_wb_scheduler;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      rv;
    logic [4:0]      ra [3];
    logic [31:0]     rd [3];
    logic [14:0]     req_addr;
    logic [95:0]     req_data;
    logic [2:0]      req_ready;
    logic            rsv_valid;
    logic [4:0]      rsv_addr;
    logic            rsv_ready;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [31:0]     rf_wdata;
    logic [31:0]     busy_vec;

    assign req_addr = {ra[2], ra[1], ra[0]};
    assign req_data = {rd[2], rd[1], rd[0]};

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (rv),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy_vec  (busy_vec)
    );

    // Register file as the design's consumer sees it
    logic [31:0] rfm [32];
    always @(posedge clk)
        if (!rst && rf_we) rfm[rf_waddr] <= rf_wdata;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Behavioural model: pending set, last winner, in-flight write
    bit          mb [32];
    int          last;
    bit          pw;
    int          pa;
    logic [31:0] pd;
    int          eg;
    bit          exp_rsv;

    task automatic model_reset();
        foreach (mb[i]) mb[i] = 1'b0;
        last = NREQ - 1;
        pw   = 1'b0;
        pa   = 0;
        pd   = '0;
    endtask

    task automatic sample();
        logic [31:0] bv;
        logic [2:0]  er;
        @(negedge clk);
        eg = -1;
        for (int k = 1; k <= NREQ; k++)
            if (eg < 0 && rv[(last + k) % NREQ]) eg = (last + k) % NREQ;
        er = '0;
        if (eg >= 0) er[eg] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("rf_we", rf_we, pw);
        if (pw) begin
            chk("rf_waddr", rf_waddr, pa);
            chk("rf_wdata", rf_wdata, pd);
        end
        exp_rsv = !mb[rsv_addr] || (pw && pa == rsv_addr);
        chk("rsv_ready", rsv_ready, exp_rsv);
        chk("rs1_busy", rs1_busy, mb[rs1_addr]);
        chk("rs2_busy", rs2_busy, mb[rs2_addr]);
        for (int i = 0; i < 32; i++) bv[i] = mb[i];
        chk("busy_vec", busy_vec, bv);
    endtask

    task automatic tick();
        @(posedge clk);
        if (pw) mb[pa] = 1'b0;
        if (rsv_valid && exp_rsv && rsv_addr != 0) mb[rsv_addr] = 1'b1;
        if (eg >= 0) begin
            last = eg;
            pw   = (ra[eg] != 0);
            pa   = ra[eg];
            pd   = rd[eg];
        end else begin
            pw = 1'b0;
        end
        #1;
    endtask

    logic [31:0] seqd [3];

    initial begin
        seqd = '{32'hDEADBEEF, 32'h12345678, 32'h0BADF00D};
        foreach (rfm[i]) rfm[i] = '0;
        rst = 1'b1;
        rv = '0;
        foreach (ra[i]) begin ra[i] = '0; rd[i] = '0; end
        rsv_valid = 1'b0; rsv_addr = '0; rs1_addr = '0; rs2_addr = '0;
        model_reset();
        #3;
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_busy", busy_vec, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // All three valid: grants rotate 0,1,2
        rv = 3'b111;
        for (int i = 0; i < 3; i++) begin ra[i] = 5'(5 + i); rd[i] = seqd[i]; end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rv = '0;
            sample();
            if (i < 3) chk("gnt_seq", req_ready, 3'b001 << i);
            if (i > 0) begin
                chk("seq_addr", rf_waddr, 5 + i - 1);
                chk("seq_data", rf_wdata, seqd[i-1]);
            end
            tick();
        end

        // Reserve x9, then resolve it through requester 1
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        sample(); tick();
        rs1_addr = 5'd9;
        rv = 3'b010; ra[1] = 5'd9; rd[1] = 32'h11111111;
        sample();
        chk("x9_busy", rs1_busy, 1);
        chk("x9_waw_stall", rsv_ready, 0);
        tick();
        rv = '0;
        sample();
        chk("x9_commit_rsv", rsv_ready, 1);
        tick();
        rsv_valid = 1'b0;
        rv = 3'b010; rd[1] = 32'hA5A5A5A5;
        sample();
        chk("x9_rebusy", busy_vec[9], 1);
        tick();
        rv = '0;
        sample();
        chk("x9_we", rf_we, 1);
        chk("x9_wdata", rf_wdata, 32'hA5A5A5A5);
        tick();
        sample();
        chk("x9_clear", rs1_busy, 0);
        chk("x9_readback", rfm[9], 32'hA5A5A5A5);
        tick();

        // x0 write is accepted but never reaches the register file
        rv = 3'b100; ra[2] = 5'd0; rd[2] = 32'hFFFFFFFF;
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        sample();
        chk("x0_ready", req_ready, 3'b100);
        chk("x0_rsv_ready", rsv_ready, 1);
        tick();
        rv = '0; rsv_valid = 1'b0;
        sample();
        chk("x0_no_we", rf_we, 0);
        chk("x0_busy", busy_vec, 0);
        chk("x0_reads0", rfm[0], 0);
        tick();

        // Requester 2 alone streams, then alternates with requester 0
        rv = 3'b100;
        for (int i = 0; i < 4; i++) begin
            ra[2] = 5'(10 + i); rd[2] = $urandom;
            sample();
            chk("stream_gnt", req_ready, 3'b100);
            if (i > 0) chk("stream_we", rf_we, 1);
            tick();
        end
        rv = 3'b101; ra[0] = 5'd20; rd[0] = $urandom;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("alt_gnt", req_ready, (i % 2 == 0) ? 3'b001 : 3'b100);
            tick();
            rd[eg] = $urandom;
        end
        rv = '0;
        sample(); tick();

        // Asynchronous reset with a write in flight and a reservation held
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        rv = 3'b001; ra[0] = 5'd4; rd[0] = 32'hCAFE0004;
        sample(); tick();
        rv = '0; rsv_valid = 1'b0;
        chk("pre_rst_we", rf_we, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_we", rf_we, 0);
        chk("async_rst_busy", busy_vec, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        rv = 3'b110; ra[1] = 5'd12; ra[2] = 5'd13;
        sample();
        chk("post_rst_gnt", req_ready, 3'b010);
        tick();
        rv = '0;

        // Random traffic against the model
        repeat (400) begin
            for (int i = 0; i < NREQ; i++)
                if (!rv[i] && $urandom_range(0, 1) == 1) begin
                    rv[i] = 1'b1;
                    ra[i] = 5'($urandom_range(0, 7));
                    rd[i] = $urandom;
                end
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr  = 5'($urandom_range(0, 7));
            rs1_addr  = 5'($urandom_range(0, 7));
            rs2_addr  = 5'($urandom_range(0, 7));
            sample();
            tick();
            if (eg >= 0) rv[eg] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
